// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, funct encodings and sequencer state encoding
// for the MIPS ALU control block.
package alu_ctrl_pkg;

    localparam logic [5:0] ALU_ADD  = 6'h00;
    localparam logic [5:0] ALU_SUB  = 6'h01;
    localparam logic [5:0] ALU_MULT = 6'h02;
    localparam logic [5:0] ALU_DIV  = 6'h03;
    localparam logic [5:0] ALU_OR   = 6'h04;
    localparam logic [5:0] ALU_AND  = 6'h05;
    localparam logic [5:0] ALU_NOT  = 6'h06;
    localparam logic [5:0] ALU_SLT  = 6'h07;
    localparam logic [5:0] ALU_SLE  = 6'h24;
    localparam logic [5:0] ALU_SGE  = 6'h25;

    localparam logic [5:0] F_ADD  = 6'h00;
    localparam logic [5:0] F_SUB  = 6'h01;
    localparam logic [5:0] F_MULT = 6'h02;
    localparam logic [5:0] F_DIV  = 6'h03;
    localparam logic [5:0] F_OR   = 6'h04;
    localparam logic [5:0] F_AND  = 6'h05;
    localparam logic [5:0] F_NOT  = 6'h06;
    localparam logic [5:0] F_SLT  = 6'h07;
    localparam logic [5:0] F_SLE  = 6'h24;
    localparam logic [5:0] F_SGE  = 6'h25;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational resolution of (ALU_Op, Funct, Sinal) into an ALU control code,
// an illegal-funct flag and a multi-cycle classification.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 6,
    parameter int FUNCT_W = 6
) (
    input  logic               alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [CTRL_W-1:0]  sinal,
    output logic [CTRL_W-1:0]  code,
    output logic               illegal,
    output logic               is_multi
);

    // Full-width compare: any set bit above bit 5 misses every item.
    always_comb begin
        code    = '0;
        illegal = 1'b0;
        if (alu_op) begin
            case (funct)
                FUNCT_W'(F_ADD):  code = CTRL_W'(ALU_ADD);
                FUNCT_W'(F_SUB):  code = CTRL_W'(ALU_SUB);
                FUNCT_W'(F_MULT): code = CTRL_W'(ALU_MULT);
                FUNCT_W'(F_DIV):  code = CTRL_W'(ALU_DIV);
                FUNCT_W'(F_OR):   code = CTRL_W'(ALU_OR);
                FUNCT_W'(F_AND):  code = CTRL_W'(ALU_AND);
                FUNCT_W'(F_NOT):  code = CTRL_W'(ALU_NOT);
                FUNCT_W'(F_SLT):  code = CTRL_W'(ALU_SLT);
                FUNCT_W'(F_SLE):  code = CTRL_W'(ALU_SLE);
                FUNCT_W'(F_SGE):  code = CTRL_W'(ALU_SGE);
                default:          illegal = 1'b1;
            endcase
        end else begin
            code = sinal;
        end
    end

    assign is_multi = (code == CTRL_W'(ALU_MULT)) || (code == CTRL_W'(ALU_DIV));

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control with issue handshake; mult/div hold the code and
// stall the pipeline for a configurable number of cycles.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W      = 6,
    parameter int FUNCT_W     = 6,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Issue,
    input  logic               ALU_Op,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [CTRL_W-1:0]  Sinal,
    output logic [CTRL_W-1:0]  ALU_Ctrl,
    output logic               Busy,
    output logic               Stall,
    output logic               Done,
    output logic               Illegal
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    logic [CTRL_W-1:0] code;
    logic              illegal;
    logic              is_multi;
    logic              accept;
    logic [CNT_W-1:0]  lat_m1;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              done_r;
    logic              ill_r;

    alu_funct_decode #(
        .CTRL_W  (CTRL_W),
        .FUNCT_W (FUNCT_W)
    ) u_dec (
        .alu_op   (ALU_Op),
        .funct    (Funct),
        .sinal    (Sinal),
        .code     (code),
        .illegal  (illegal),
        .is_multi (is_multi)
    );

    assign accept = Issue && (state == IDLE);
    assign lat_m1 = (code == CTRL_W'(ALU_DIV)) ? CNT_W'(DIV_CYCLES - 1)
                                               : CNT_W'(MULT_CYCLES - 1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ALU_Ctrl <= '0;
            done_r   <= 1'b0;
            ill_r    <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            done_r <= accept && !is_multi;
            ill_r  <= accept && illegal;
            if (accept)
                ALU_Ctrl <= code;
        end
    end

    // Counter holds LAT-k during RUN cycle k, so zero marks the last cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept && is_multi) begin
                    state_nx = RUN;
                    cnt_nx   = lat_m1;
                end
            end
            RUN: begin
                if (cnt == '0)
                    state_nx = IDLE;
                else
                    cnt_nx = cnt - 1'b1;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign Busy    = (state == RUN);
    assign Stall   = Busy;
    assign Done    = done_r || ((state == RUN) && (cnt == '0));
    assign Illegal = ill_r;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: single-cycle vector table, multi-cycle
// sequences, reset abort and a short/long latency parameter instance.
module tb_alu_ctrl_seq;

    logic       Clock = 1'b0;
    logic       Reset, Issue, ALU_Op;
    logic [5:0] Funct, Sinal, ALU_Ctrl;
    logic       Busy, Stall, Done, Illegal;

    logic       Reset_s, Issue_s, ALU_Op_s;
    logic [5:0] Funct_s, Sinal_s, ALU_Ctrl_s;
    logic       Busy_s, Stall_s, Done_s, Illegal_s;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    alu_ctrl_seq #(.CTRL_W(6), .FUNCT_W(6), .MULT_CYCLES(4), .DIV_CYCLES(8)) dut (
        .Clock(Clock), .Reset(Reset), .Issue(Issue), .ALU_Op(ALU_Op),
        .Funct(Funct), .Sinal(Sinal), .ALU_Ctrl(ALU_Ctrl), .Busy(Busy),
        .Stall(Stall), .Done(Done), .Illegal(Illegal)
    );

    alu_ctrl_seq #(.CTRL_W(6), .FUNCT_W(6), .MULT_CYCLES(2), .DIV_CYCLES(33)) dut_s (
        .Clock(Clock), .Reset(Reset_s), .Issue(Issue_s), .ALU_Op(ALU_Op_s),
        .Funct(Funct_s), .Sinal(Sinal_s), .ALU_Ctrl(ALU_Ctrl_s), .Busy(Busy_s),
        .Stall(Stall_s), .Done(Done_s), .Illegal(Illegal_s)
    );

    typedef struct {
        logic       alu_op;
        logic [5:0] funct;
        logic [5:0] sinal;
        logic [5:0] exp_ctrl;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issue one multi-cycle op on dut and follow it to completion.
    // ign_k != 0 presents a stray add Issue during that busy cycle.
    task automatic run_multi(input logic op, input logic [5:0] f, input logic [5:0] s,
                             input logic [5:0] code, input int lat, input int ign_k);
        Issue = 1'b1; ALU_Op = op; Funct = f; Sinal = s;
        tick();
        Issue = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk($sformatf("busy_c%0d", k), Busy, 1'b1);
            chk($sformatf("stall_c%0d", k), Stall, 1'b1);
            chk($sformatf("ctrl_c%0d", k), ALU_Ctrl, code);
            chk($sformatf("done_c%0d", k), Done, (k == lat));
            chk($sformatf("ill_c%0d", k), Illegal, 1'b0);
            if (k == ign_k) begin
                Issue = 1'b1; ALU_Op = 1'b1; Funct = 6'h00;
            end else begin
                Issue = 1'b0;
            end
            tick();
        end
        Issue = 1'b0;
        chk("busy_after", Busy, 1'b0);
        chk("done_after", Done, 1'b0);
        chk("ctrl_after", ALU_Ctrl, code);
    endtask

    initial begin
        int n;
        logic busy_gap;

        vecs[0]  = '{1'b1, 6'h00, 6'h00, 6'h00, 1'b0};
        vecs[1]  = '{1'b1, 6'h01, 6'h00, 6'h01, 1'b0};
        vecs[2]  = '{1'b1, 6'h25, 6'h00, 6'h25, 1'b0};
        vecs[3]  = '{1'b1, 6'h04, 6'h00, 6'h04, 1'b0};
        vecs[4]  = '{1'b1, 6'h05, 6'h00, 6'h05, 1'b0};
        vecs[5]  = '{1'b1, 6'h06, 6'h00, 6'h06, 1'b0};
        vecs[6]  = '{1'b1, 6'h07, 6'h00, 6'h07, 1'b0};
        vecs[7]  = '{1'b1, 6'h24, 6'h00, 6'h24, 1'b0};
        vecs[8]  = '{1'b1, 6'h3F, 6'h11, 6'h00, 1'b1};
        vecs[9]  = '{1'b1, 6'h08, 6'h00, 6'h00, 1'b1};
        vecs[10] = '{1'b1, 6'h26, 6'h00, 6'h00, 1'b1};
        vecs[11] = '{1'b0, 6'h3F, 6'h2A, 6'h2A, 1'b0};
        vecs[12] = '{1'b0, 6'h02, 6'h05, 6'h05, 1'b0};
        vecs[13] = '{1'b1, 6'h20, 6'h00, 6'h00, 1'b1};
        vecs[14] = '{1'b0, 6'h00, 6'h24, 6'h24, 1'b0};

        Reset = 1'b1; Issue = 1'b0; ALU_Op = 1'b0; Funct = '0; Sinal = '0;
        Reset_s = 1'b1; Issue_s = 1'b0; ALU_Op_s = 1'b1; Funct_s = '0; Sinal_s = '0;
        tick();
        tick();
        chk("rst_ctrl", ALU_Ctrl, 6'h00);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_stall", Stall, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_ill", Illegal, 1'b0);
        Reset = 1'b0; Reset_s = 1'b0;

        // Back-to-back single-cycle ops, one per cycle.
        for (int i = 0; i < 15; i++) begin
            Issue = 1'b1; ALU_Op = vecs[i].alu_op; Funct = vecs[i].funct; Sinal = vecs[i].sinal;
            tick();
            chk($sformatf("vec%0d_ctrl", i), ALU_Ctrl, vecs[i].exp_ctrl);
            chk($sformatf("vec%0d_done", i), Done, 1'b1);
            chk($sformatf("vec%0d_ill", i), Illegal, vecs[i].exp_ill);
            chk($sformatf("vec%0d_busy", i), Busy, 1'b0);
        end
        Issue = 1'b0;
        tick();
        chk("idle_done", Done, 1'b0);
        chk("idle_ill", Illegal, 1'b0);
        chk("idle_hold", ALU_Ctrl, 6'h24);

        run_multi(1'b1, 6'h02, 6'h00, 6'h02, 4, 0);
        run_multi(1'b1, 6'h03, 6'h00, 6'h03, 8, 3);
        run_multi(1'b0, 6'h3F, 6'h03, 6'h03, 8, 0);
        run_multi(1'b0, 6'h00, 6'h02, 6'h02, 4, 0);

        // Reset mid-div: abort without Done, then accept straight after.
        Issue = 1'b1; ALU_Op = 1'b1; Funct = 6'h03;
        tick();
        Issue = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", Busy, 1'b1);
        Reset = 1'b1;
        tick();
        chk("mid_rst_done", Done, 1'b0);
        chk("mid_rst_busy", Busy, 1'b0);
        tick();
        Reset = 1'b0;
        chk("post_rst_ctrl", ALU_Ctrl, 6'h00);
        chk("post_rst_busy", Busy, 1'b0);
        chk("post_rst_stall", Stall, 1'b0);
        chk("post_rst_done", Done, 1'b0);
        chk("post_rst_ill", Illegal, 1'b0);
        Issue = 1'b1; Funct = 6'h01;
        tick();
        Issue = 1'b0;
        chk("rel_ctrl", ALU_Ctrl, 6'h01);
        chk("rel_done", Done, 1'b1);

        // Short/long latency instance: count cycles to Done.
        for (int t = 0; t < 2; t++) begin
            Issue_s = 1'b1; Funct_s = (t == 0) ? 6'h02 : 6'h03;
            tick();
            Issue_s = 1'b0;
            n = 1;
            busy_gap = 1'b0;
            while (!Done_s && n < 100) begin
                if (!Busy_s || !Stall_s) busy_gap = 1'b1;
                tick();
                n++;
            end
            if (!Busy_s || !Stall_s) busy_gap = 1'b1;
            chk($sformatf("sweep%0d_lat", t), n, (t == 0) ? 2 : 33);
            chk($sformatf("sweep%0d_busy", t), busy_gap, 1'b0);
            chk($sformatf("sweep%0d_ctrl", t), ALU_Ctrl_s, Funct_s);
            chk($sformatf("sweep%0d_ill", t), Illegal_s, 1'b0);
            tick();
            chk($sformatf("sweep%0d_free", t), Busy_s, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Next-generation ALU control for the MIPS datapath. It adds a registered, parametrised control-code path with an issue handshake and a multi-cycle sequencer. Funct or Sinal resolves to an ALU control code as before. Mult and div now occupy the ALU for a configurable number of cycles, during which the block holds the code and asserts Busy/Stall to freeze the pipeline. The block sits between the main control unit/decode stage and the ALU.

Parameters:
CTRL_W, 6, width of ALU_Ctrl and Sinal.
FUNCT_W, 6, width of Funct. Must be >= 6.
MULT_CYCLES, 4, ALU occupancy for mult (code 6'h02). Must be >= 2.
DIV_CYCLES, 8, ALU occupancy for div (code 6'h03). Must be >= 2.

Ports:
Clock  in  1  rising-edge clock.
Reset  in  1  synchronous, active-high reset.
Issue  in  1  an operation is presented this cycle.
ALU_Op  in  1  1 = decode Funct; 0 = pass Sinal through.
Funct  in  FUNCT_W  R-type funct field.
Sinal  in  CTRL_W  direct control code from the main control unit.
ALU_Ctrl  out  CTRL_W  registered control code to the ALU.
Busy  out  1  a multi-cycle operation is in progress.
Stall  out  1  pipeline freeze request; equal to Busy.
Done  out  1  one-cycle pulse when the accepted operation completes.
Illegal  out  1  one-cycle pulse, coincident with Done, when an unknown Funct was decoded.

Behaviour:
- Reset values: ALU_Ctrl=0, Busy=0, Stall=0, Done=0, Illegal=0, state=IDLE, counter=0.
- Reset has priority over all other activity. Reset mid-operation aborts to IDLE with no Done pulse.
- Code resolution (combinational, internal), when ALU_Op=1:
  - 00→00 add, 01→01 sub, 02→02 mult, 03→03 div, 04→04 or, 05→05 and, 06→06 not, 07→07 slt, 24→24 sle, 25→25 sge (all hex).
  - Any other Funct resolves to 00 and marks the operation illegal.
- Code resolution when ALU_Op=0: code = Sinal, never illegal.
- Code widths: codes are zero-extended to CTRL_W. Funct bits above bit 5 must be 0 for a legal match.
- Accept rule: Issue is accepted only when Busy=0. Issue while Busy=1 is ignored, with no state change.
- Multi-cycle classification uses the resolved code, in either mode. Code 02 uses LAT=MULT_CYCLES, code 03 uses LAT=DIV_CYCLES. All other codes are single-cycle.
- Cycle numbering: the accept edge is cycle 0.
- Single-cycle op: at cycle 1, ALU_Ctrl=code, Done=1, Illegal set as decoded, Busy=0. The block remains IDLE and can accept a new Issue at cycle 1 (back-to-back issue gives one op per cycle).
- Multi-cycle op:
  - IDLE→RUN at the accept edge. Counter loads LAT-1.
  - Cycles 1..LAT: ALU_Ctrl=code (held constant), Busy=Stall=1.
  - The counter decrements each RUN cycle. Done=1 in cycle LAT, when counter=0.
  - RUN→IDLE after cycle LAT. Busy=0 from cycle LAT+1, which is the earliest cycle another Issue is accepted.
- With no accepted Issue, ALU_Ctrl holds its last value. Done and Illegal are 0.
- FSM states: IDLE, RUN. Any unreachable encoding returns to IDLE.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)).

Decomposition:
- Shared package alu_ctrl_pkg:
  - ALU code localparams: ALU_ADD, ALU_SUB, ALU_MULT, ALU_DIV, ALU_OR, ALU_AND, ALU_NOT, ALU_SLT, ALU_SLE, ALU_SGE.
  - Matching funct localparams.
  - State encoding IDLE/RUN.
- One natural sub-module, alu_funct_decode: purely combinational, maps (ALU_Op, Funct, Sinal) to (code, illegal, is_multi). The sequencer FSM and counter stay in alu_ctrl_seq.

Test Plan:
1. Reset asserted for 2 cycles mid-RUN of a div → all outputs 0 the cycle after reset. No Done pulse. A new Issue is accepted right after release.
2. ALU_Op=1, Funct=6'h01, Issue 1 cycle → cycle 1: ALU_Ctrl=6'h01, Done=1, Busy=0. Back-to-back Funct=6'h25 on the next cycle → ALU_Ctrl=6'h25 one cycle later.
3. ALU_Op=1, Funct=6'h02, MULT_CYCLES=4 → Busy/Stall=1 on cycles 1–4, ALU_Ctrl=6'h02 held, Done only on cycle 4, Busy=0 on cycle 5.
4. Div in progress (DIV_CYCLES=8); Issue with Funct=6'h00 on cycle 3 → ignored. ALU_Ctrl stays 6'h03 and Done occurs only on cycle 8.
5. ALU_Op=1, Funct=6'h3F → cycle 1: ALU_Ctrl=0, Done=1, Illegal=1. ALU_Op=0, Sinal=6'h03 → treated as div, Busy for DIV_CYCLES cycles.
6. Parameter sweep MULT_CYCLES=2, DIV_CYCLES=33 → Done on cycles 2 and 33 respectively. Counter does not wrap early.
